socetlib_edge_event_arbiter: RTL and testbench
==============================================

SOCETLIB_EDGE_EVENT_ARBITER -- requirements
Module: socetlib_edge_event_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored channels (2..16).
REQ-002 SHALL have parameter IDW, default $clog2(NCH), event channel-ID width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 signal  input  NCH  level inputs, one per channel, synchronous to CLK.
REQ-006 rise_en  input  NCH  per-channel enable for rising-edge capture.
REQ-007 fall_en  input  NCH  per-channel enable for falling-edge capture.
REQ-008 ovf_clr  input  NCH  per-channel pulse that clears the sticky overflow flag.
REQ-009 evt_ready  input  1  consumer accepts the presented event.
REQ-010 evt_valid  output  1  event presented.
REQ-011 evt_id  output  IDW  channel index of the presented event.
REQ-012 evt_rising  output  1  1 = rising edge, 0 = falling edge.
REQ-013 pending  output  NCH  per-channel captured-but-unaccepted flag.
REQ-014 overflow  output  NCH  per-channel sticky flag for dropped edges.

Function
REQ-015 Edge detection: pos = signal & ~signal_q, neg = ~signal & signal_q, where signal_q is signal registered once.
REQ-016 Capture: when pending[i]=0 and (pos[i]&rise_en[i] | neg[i]&fall_en[i]), the next edge sets pending[i]=1 and type[i]=pos[i].
REQ-017 Enables gate capture only; clearing an enable does not drop an already pending event.
REQ-018 Overflow: a qualified edge on channel i while pending[i]=1 and channel i is not being accepted that cycle sets overflow[i]=1; the new edge is dropped and the stored type is kept.
REQ-019 Simultaneous accept and edge on the same channel: pending[i] stays 1 with type[i] from the new edge; overflow[i] unchanged.
REQ-020 ovf_clr[i] clears overflow[i]; a simultaneous overflow set on channel i wins.
REQ-021 FSM states IDLE and BUSY.
REQ-022 IDLE: if any pending bit is set, register the round-robin winner into evt_id/evt_rising, set evt_valid=1, go to BUSY; else stay.
REQ-023 Round-robin: search starts at last_grant+1, wraps modulo NCH; first pending channel wins.
REQ-024 BUSY: evt_valid, evt_id, and evt_rising hold stable until evt_ready=1.
REQ-025 BUSY with evt_ready=1: clear pending[evt_id] (subject to REQ-019), set last_grant=evt_id, set evt_valid=0, go to IDLE.
REQ-026 Latency: an edge on signal in cycle N sets pending at the end of N; evt_valid=1 in N+1 if the FSM is IDLE and the channel wins.
REQ-027 Throughput: at most one event per two cycles, with one IDLE cycle between handshakes.
REQ-028 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-029 nRST low asynchronously forces state=IDLE, evt_valid=0, evt_id=0, evt_rising=0, pending=0, overflow=0, type=0, last_grant=NCH-1 (channel 0 has first priority).
REQ-030 During reset, signal_q loads the current signal, so no edge is reported in the first cycle after release.
REQ-031 Reset mid-handshake discards the presented event and all pending events without an overflow indication.

Structure
REQ-032 Package socetlib_edge_arb_pkg SHALL hold the state enum typedef (IDLE, BUSY) and the NCH/IDW range-check constants.
REQ-033 SHALL instantiate socetlib_edge_detector with WIDTH=NCH for REQ-015 and REQ-030; pending, overflow, arbiter, and FSM are local.

Verification
REQ-034 Single rise: NCH=4, rise_en=4'hF, signal[2] 0->1 at cycle 10, evt_ready=1 -> evt_valid=1 at cycle 11 with evt_id=2, evt_rising=1; pending=0 after cycle 11.
REQ-035 Round-robin: channels 0,1,3 edge in the same cycle, evt_ready=1 -> grants in order 0,1,3, then 0,1,3 again after a repeat, with one IDLE cycle between grants.
REQ-036 Backpressure and overflow: ch1 falls with fall_en[1]=1 and evt_ready=0 for 6 cycles, ch1 rises then falls again -> evt_id=1, evt_rising=0 held stable; overflow[1]=1; ovf_clr[1] pulse -> overflow[1]=0.
REQ-037 Accept collision: ch0 event accepted in the same cycle ch0 sees a new rising edge -> pending[0] stays 1, overflow[0]=0, next event is id 0 rising.
REQ-038 Enable masking: rise_en=0, fall_en[3]=1, ch3 pulses 0->1->0 -> exactly one event, id 3, evt_rising=0.
REQ-039 Reset: assert nRST during BUSY with signal=4'hF held -> all outputs 0 immediately; after release, no event until signal changes.

Source files
------------

// File: rtl/socetlib_edge_arb_pkg.sv
// Shared types and parameter limits for the edge event arbiter.
//   state_t  : handshake FSM state (IDLE, BUSY)
//   NCH_MIN/NCH_MAX : legal channel-count range
//   idw_min() : narrowest channel-ID width that can name every channel
package socetlib_edge_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;

  function automatic int idw_min(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/socetlib_edge_detector.sv
// Registers a level vector once and reports rising/falling edges.
//   CLK    : clock
//   signal : level inputs
//   pos    : signal & ~signal_q
//   neg    : ~signal & signal_q
// signal_q carries no reset: it keeps sampling while the rest of the block is
// held in reset, so the first cycle after release compares against a current
// value and never reports a phantom edge.
module socetlib_edge_detector #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] pos,
  output logic [WIDTH-1:0] neg
);

  logic [WIDTH-1:0] signal_q;

  always_ff @(posedge CLK) signal_q <= signal;

  assign pos = signal  & ~signal_q;
  assign neg = ~signal &  signal_q;

endmodule

// File: rtl/socetlib_edge_event_arbiter.sv
// Captures qualified edges on NCH channels into per-channel pending slots and
// hands them to one consumer in round-robin order over a valid/ready port.
//   CLK, nRST         : clock, async active-low reset
//   signal            : channel levels
//   rise_en, fall_en  : per-channel edge qualifiers
//   ovf_clr           : per-channel overflow clear pulse
//   evt_ready         : consumer accepts presented event
//   evt_valid/evt_id/evt_rising : presented event (registered)
//   pending, overflow : per-channel status
module socetlib_edge_event_arbiter #(
  parameter int NCH = 4,
  parameter int IDW = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic [NCH-1:0] signal,
  input  logic [NCH-1:0] rise_en,
  input  logic [NCH-1:0] fall_en,
  input  logic [NCH-1:0] ovf_clr,
  input  logic           evt_ready,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic           evt_rising,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] overflow
);
  import socetlib_edge_arb_pkg::*;

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("NCH out of range");
  end
  if (IDW < idw_min(NCH)) begin : g_bad_idw
    $error("IDW too narrow for NCH");
  end

  logic [NCH-1:0] pos, neg, qual, acc, cand, evt_type;
  logic [IDW-1:0] last_grant, win;
  logic           found, win_rising;
  int             idx;
  state_t         state;

  socetlib_edge_detector #(.WIDTH(NCH)) u_edge (
    .CLK    (CLK),
    .signal (signal),
    .pos    (pos),
    .neg    (neg)
  );

  assign qual = (pos & rise_en) | (neg & fall_en);

  // One-hot accept of the presented channel; evt_valid==1 exactly in BUSY,
  // so evt_ready outside a presentation never produces an accept.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NCH; i++)
      acc[i] = (state == BUSY) && evt_ready && (evt_id == IDW'(i));
  end

  // Arbitrate over stored pending bits plus edges captured this cycle, so an
  // edge in cycle N is presented in N+1 together with its pending bit.
  assign cand = pending | qual;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_grant) + k) % NCH;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // A stored event keeps its type; a freshly captured one takes the edge.
  assign win_rising = pending[win] ? evt_type[win] : pos[win];

  // Pending / type / overflow slots.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending  <= '0;
      evt_type <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (qual[i] && (!pending[i] || acc[i])) begin
          pending[i]  <= 1'b1;
          evt_type[i] <= pos[i];
        end else if (acc[i]) begin
          pending[i]  <= 1'b0;
        end
        // Set beats clear when both land in the same cycle.
        if (qual[i] && pending[i] && !acc[i]) overflow[i] <= 1'b1;
        else if (ovf_clr[i])                  overflow[i] <= 1'b0;
      end
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_rising <= 1'b0;
      last_grant <= IDW'(NCH - 1);
    end else begin
      case (state)
        IDLE: if (found) begin
          evt_valid  <= 1'b1;
          evt_id     <= win;
          evt_rising <= win_rising;
          state      <= BUSY;
        end
        BUSY: if (evt_ready) begin
          evt_valid  <= 1'b0;
          last_grant <= evt_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_socetlib_edge_event_arbiter.sv
module tb_socetlib_edge_event_arbiter;
  localparam int NCH = 4;
  localparam int IDW = 2;

  logic           CLK = 1'b0;
  logic           nRST;
  logic [NCH-1:0] signal, rise_en, fall_en, ovf_clr;
  logic           evt_ready;
  logic           evt_valid, evt_rising;
  logic [IDW-1:0] evt_id;
  logic [NCH-1:0] pending, overflow;

  int checks = 0;
  int errors = 0;

  socetlib_edge_event_arbiter #(.NCH(NCH), .IDW(IDW)) dut (
    .CLK(CLK), .nRST(nRST), .signal(signal), .rise_en(rise_en),
    .fall_en(fall_en), .ovf_clr(ovf_clr), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_rising(evt_rising),
    .pending(pending), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset(input logic [NCH-1:0] sig);
    signal = sig;
    nRST   = 1'b0;
    step(); step();
    nRST   = 1'b1;
  endtask

  task automatic expect_evt(input string tag, input logic [IDW-1:0] id, input logic r);
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_id"}, 32'(evt_id), 32'(id));
    check({tag, "_rising"}, 32'(evt_rising), 32'(r));
  endtask

  logic [IDW-1:0] order [3];

  initial begin
    nRST = 1'b0; signal = '0; rise_en = '0; fall_en = '0; ovf_clr = '0; evt_ready = 1'b0;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3;

    // Reset state
    apply_reset(4'h0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_rising", 32'(evt_rising), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single rise on ch2, immediate accept
    rise_en = 4'hF; evt_ready = 1'b1;
    signal = 4'b0100; step();
    expect_evt("single", 2'd2, 1'b1);
    check("single_pend", 32'(pending), 32'h4);
    step();
    check("single_done_valid", 32'(evt_valid), 32'd0);
    check("single_done_pend", 32'(pending), 32'h0);

    // Round robin 0,1,3 twice with an idle cycle between grants
    apply_reset(4'h0);
    for (int rep = 0; rep < 2; rep++) begin
      signal = 4'h0; step();
      signal = 4'b1011; step();
      for (int g = 0; g < 3; g++) begin
        expect_evt($sformatf("rr%0d_%0d", rep, g), order[g], 1'b1);
        step();
        check($sformatf("rr%0d_%0d_idle", rep, g), 32'(evt_valid), 32'd0);
        step();
      end
      check($sformatf("rr%0d_pend", rep), 32'(pending), 32'h0);
    end

    // Backpressure and overflow on ch1
    evt_ready = 1'b0; rise_en = 4'hF; fall_en = 4'hF;
    apply_reset(4'b0010);
    signal = 4'b0000; step();
    expect_evt("bp_first", 2'd1, 1'b0);
    check("bp_ovf0", 32'(overflow), 32'h0);
    signal = 4'b0010; step();
    expect_evt("bp_hold_rise", 2'd1, 1'b0);
    check("bp_ovf1", 32'(overflow), 32'h2);
    signal = 4'b0000; step();
    expect_evt("bp_hold_fall", 2'd1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      expect_evt($sformatf("bp_hold%0d", c), 2'd1, 1'b0);
    end
    check("bp_ovf_sticky", 32'(overflow), 32'h2);
    ovf_clr = 4'b0010; step(); ovf_clr = '0;
    check("bp_ovf_clr", 32'(overflow), 32'h0);
    check("bp_still_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1; step();
    check("bp_acc_valid", 32'(evt_valid), 32'd0);
    check("bp_acc_pend", 32'(pending), 32'h0);
    step();
    check("bp_no_more", 32'(evt_valid), 32'd0);

    // Accept colliding with a new rising edge on ch0
    evt_ready = 1'b0; rise_en = 4'hF; fall_en = 4'h0;
    apply_reset(4'h0);
    signal = 4'b0001; step();
    expect_evt("col_first", 2'd0, 1'b1);
    signal = 4'b0000; step();
    expect_evt("col_hold", 2'd0, 1'b1);
    signal = 4'b0001; evt_ready = 1'b1; step();
    check("col_valid", 32'(evt_valid), 32'd0);
    check("col_pend", 32'(pending), 32'h1);
    check("col_ovf", 32'(overflow), 32'h0);
    step();
    expect_evt("col_next", 2'd0, 1'b1);
    step();
    check("col_pend_done", 32'(pending), 32'h0);

    // Enable masking: only ch3 falling is qualified
    evt_ready = 1'b1; rise_en = 4'h0; fall_en = 4'b1000;
    apply_reset(4'h0);
    signal = 4'b1000; step();
    check("mask_rise_valid", 32'(evt_valid), 32'd0);
    check("mask_rise_pend", 32'(pending), 32'h0);
    signal = 4'b0000; step();
    expect_evt("mask_fall", 2'd3, 1'b0);
    step();
    check("mask_after0", 32'(evt_valid), 32'd0);
    step();
    check("mask_after1", 32'(evt_valid), 32'd0);

    // Reset during BUSY with all signals high
    evt_ready = 1'b0; rise_en = 4'hF; fall_en = 4'h0;
    apply_reset(4'h0);
    signal = 4'hF; step();
    expect_evt("mr_busy", 2'd0, 1'b1);
    #2 nRST = 1'b0; #1;
    check("mr_valid", 32'(evt_valid), 32'd0);
    check("mr_id", 32'(evt_id), 32'd0);
    check("mr_rising", 32'(evt_rising), 32'd0);
    check("mr_pend", 32'(pending), 32'h0);
    check("mr_ovf", 32'(overflow), 32'h0);
    step(); step(); step();
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("mr_quiet%0d", c), 32'({evt_valid, pending}), 32'h0);
    end
    fall_en = 4'hF; signal = 4'h7; step();
    expect_evt("mr_after", 2'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
